// File: rtl/iter_div_unit.sv
// iter_div_unit: multi-cycle RV32M divider (DIV/DIVU/REM/REMU).
// Radix-2 restoring algorithm, one quotient bit per cycle, XLEN cycles in CALC.
// Division by zero and signed overflow bypass the iteration.
// stall_req holds IF/ID while an op is being accepted or computed.
// Optional feature macro: DIV_EARLY_OUT_EN. When it is defined, a dividend
// magnitude smaller than the divisor magnitude also bypasses the iteration.
module iter_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Two's-complement negation, XLEN bits, wrapping.
  function automatic logic [XLEN-1:0] neg_f(input logic [XLEN-1:0] v);
    return ~v + ONE;
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] div_q, div_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            rem_sel_q, rem_sel_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;

  // Operand decode: signs and magnitudes (magnitudes only for signed ops).
  logic            is_signed_s, is_rem_s, sign1_s, sign2_s;
  logic [XLEN-1:0] abs1_s, abs2_s;
  logic            div_zero_s, ovf_s;
  // One restoring-division step on the current partial remainder.
  logic [XLEN:0]   rem_sh_s;
  logic [XLEN-1:0] sub_s, rem_nx_s, quo_nx_s, quo_fix_s, rem_fix_s;
  logic            no_borrow_s;

  // Operand decode and the iteration datapath.
  always_comb begin
    is_signed_s = ~op[0];
    is_rem_s    = op[1];
    sign1_s     = is_signed_s & src1[XLEN-1];
    sign2_s     = is_signed_s & src2[XLEN-1];
    abs1_s      = sign1_s ? neg_f(src1) : src1;
    abs2_s      = sign2_s ? neg_f(src2) : src2;
    div_zero_s  = (src2 == '0);
    ovf_s       = is_signed_s & (src1 == MIN_NEG) & (src2 == '1);
    rem_sh_s    = {rem_q, quo_q[XLEN-1]};
    no_borrow_s = (rem_sh_s >= {1'b0, div_q});
    // The difference always fits in XLEN bits when no borrow occurs.
    sub_s       = rem_sh_s[XLEN-1:0] - div_q;
    rem_nx_s    = no_borrow_s ? sub_s : rem_sh_s[XLEN-1:0];
    quo_nx_s    = {quo_q[XLEN-2:0], no_borrow_s};
    quo_fix_s   = neg_quo_q ? neg_f(quo_nx_s) : quo_nx_s;
    rem_fix_s   = neg_rem_q ? neg_f(rem_nx_s) : rem_nx_s;
  end

  // Next-state logic, stall request and result capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    rem_sel_d = rem_sel_q;
    done_d    = 1'b0;
    result_d  = result_q;
    stall_req = 1'b0;
    if (flush) begin
      // Abort: back to IDLE, no done pulse, last result kept.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            stall_req = 1'b1;
            rem_sel_d = is_rem_s;
            if (div_zero_s) begin
              result_d = is_rem_s ? src1 : '1;
              done_d   = 1'b1;
              state_d  = S_DONE;
            end else if (ovf_s) begin
              result_d = is_rem_s ? '0 : src1;
              done_d   = 1'b1;
              state_d  = S_DONE;
`ifdef DIV_EARLY_OUT_EN
            end else if (abs1_s < abs2_s) begin
              result_d = is_rem_s ? src1 : '0;
              done_d   = 1'b1;
              state_d  = S_DONE;
`endif
            end else begin
              rem_d     = '0;
              quo_d     = abs1_s;
              div_d     = abs2_s;
              neg_quo_d = sign1_s ^ sign2_s;
              neg_rem_d = sign1_s;
              cnt_d     = CW'(XLEN - 1);
              state_d   = S_CALC;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CALC: begin
          stall_req = 1'b1;
          rem_d     = rem_nx_s;
          quo_d     = quo_nx_s;
          if (cnt_q == '0) begin
            result_d = rem_sel_q ? rem_fix_s : quo_fix_s;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rem_sel_q <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      rem_sel_q <= rem_sel_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_iter_div_unit.sv
// Self-checking bench for iter_div_unit: directed vectors, flush, reset
// mid-calculation, held start, and randomized ops against an arithmetic model.
module tb_iter_div_unit;

  localparam int XLEN = 32;
  localparam int FULL_LAT = XLEN + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] src1, src2;
  logic            flush;
  logic            stall_req, done;
  logic [XLEN-1:0] result;

  int checks = 0;
  int errors = 0;

  iter_div_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src1(src1), .src2(src2),
    .flush(flush), .stall_req(stall_req), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Reference: RISC-V divide semantics from plain arithmetic.
  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : a;
    case (o)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  // Reference latency (start cycle 0 -> done cycle N).
  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    ma = (!o[0] && a[31]) ? 32'd0 - a : a;
    mb = (!o[0] && b[31]) ? 32'd0 - b : b;
    if (b == 32'd0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 1;
`endif
    return FULL_LAT;
  endfunction

  // Issue one op at the current negedge, track it to done; ends at a negedge in IDLE.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
    int cyc;
    bit stall_bad;
    bit seen;
    op = o; src1 = a; src2 = b; start = 1'b1;
    #1;
    checks++;
    if (stall_req !== 1'b1) begin
      errors++; $display("FAIL %s stall_at_start: got %b want 1", name, stall_req);
    end
    @(negedge clk); start = 1'b0; #1;
    cyc = 1; stall_bad = 1'b0; seen = 1'b0;
    while (!seen && cyc <= 200) begin
      if (done === 1'b1) seen = 1'b1;
      else begin
        if (stall_req !== 1'b1) stall_bad = 1'b1;
        @(negedge clk); cyc++;
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL %s timeout: no done within 200 cycles", name);
    end else if (cyc != exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
    end
    checks++;
    if (stall_bad) begin
      errors++; $display("FAIL %s stall_window: stall_req dropped before done", name);
    end
    checks++;
    if (result !== exp_res) begin
      errors++; $display("FAIL %s result: got %h want %h", name, result, exp_res);
    end
    checks++;
    if (stall_req !== 1'b0) begin
      errors++; $display("FAIL %s stall_at_done: got %b want 0", name, stall_req);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL %s done_pulse_width: got %b want 0", name, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; src1 = '0; src2 = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b0 || stall_req !== 1'b0 || result !== 32'd0) begin
      errors++; $display("FAIL reset_state: done=%b stall=%b result=%h want 0 0 0", done, stall_req, result);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, FULL_LAT, 32'd14);
    run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, FULL_LAT, 32'hFFFF_FFFF);
    run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, FULL_LAT, 32'hFFFF_FFFD);
    run_op("div_5_0", 2'b00, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
    run_op("remu_5_0", 2'b11, 32'd5, 32'd0, 1, 32'd5);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);
    run_op("divu_3_10", 2'b01, 32'd3, 32'd10, ref_lat(2'b01, 32'd3, 32'd10), 32'd0);
    run_op("div_0_5", 2'b00, 32'd0, 32'd5, ref_lat(2'b00, 32'd0, 32'd5), 32'd0);
    run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, FULL_LAT, 32'd1);
  endtask

  task automatic test_flush();
    bit done_seen;
    run_op("flush_pre", 2'b01, 32'd100, 32'd7, FULL_LAT, 32'd14);
    op = 2'b01; src1 = 32'd1000; src2 = 32'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    done_seen = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (done === 1'b1) done_seen = 1'b1;
      @(negedge clk);
    end
    flush = 1'b1; #1;
    checks++;
    if (stall_req !== 1'b0) begin
      errors++; $display("FAIL flush_stall: got %b want 0", stall_req);
    end
    @(negedge clk); flush = 1'b0; #1;
    if (done === 1'b1) done_seen = 1'b1;
    checks++;
    if (done_seen) begin
      errors++; $display("FAIL flush_no_done: got done pulse want none");
    end
    checks++;
    if (result !== 32'd14) begin
      errors++; $display("FAIL flush_result_kept: got %h want %h", result, 32'd14);
    end
    run_op("after_flush_divu_9_3", 2'b01, 32'd9, 32'd3, FULL_LAT, 32'd3);
  endtask

  task automatic test_back_to_back();
    int first, second, cyc;
    logic [31:0] r1, r2;
    first = 0; second = 0; r1 = '0; r2 = '0;
    op = 2'b01; src1 = 32'd100; src2 = 32'd7; start = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (second == 0 && cyc <= 200) begin
      if (done === 1'b1) begin
        if (first == 0) begin first = cyc; r1 = result; end
        else begin second = cyc; r2 = result; end
      end
      if (second == 0) begin @(negedge clk); cyc++; end
    end
    start = 1'b0;
    checks++;
    if (first != FULL_LAT || second != 2 * FULL_LAT + 1) begin
      errors++; $display("FAIL b2b_timing: got %0d,%0d want %0d,%0d", first, second, FULL_LAT, 2 * FULL_LAT + 1);
    end
    checks++;
    if (r1 !== 32'd14 || r2 !== 32'd14) begin
      errors++; $display("FAIL b2b_result: got %h,%h want %h", r1, r2, 32'd14);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_calc();
    bit done_seen;
    op = 2'b01; src1 = 32'd1000; src2 = 32'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1; #1;
    checks++;
    if (done !== 1'b0 || stall_req !== 1'b0 || result !== 32'd0) begin
      errors++; $display("FAIL rst_mid_calc: done=%b stall=%b result=%h want 0 0 0", done, stall_req, result);
    end
    @(negedge clk); rst = 1'b0;
    done_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1 || stall_req === 1'b1) done_seen = 1'b1;
    end
    checks++;
    if (done_seen) begin
      errors++; $display("FAIL rst_mid_calc_idle: got activity after reset want none");
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b;
    int mode;
    for (int n = 0; n < 40; n++) begin
      o = 2'($urandom_range(0, 3));
      mode = $urandom_range(0, 5);
      case (mode)
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 60); b = $urandom_range(1, 12); end
        3: begin b = $urandom; a = b >> $urandom_range(1, 8); end
        4: begin a = 32'd0 - $urandom_range(1, 1000); b = $urandom_range(1, 50); end
        default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
      endcase
      run_op($sformatf("rand%0d_op%0d", n, o), o, a, b, ref_lat(o, a, b), ref_res(o, a, b));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_back_to_back();
    test_reset_mid_calc();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
